// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the program-counter slice.
package pc_pkg;

  localparam int unsigned PC_WIDTH        = 32;
  localparam int unsigned PC_STEP         = 4;
  localparam int unsigned PC_RESET_VECTOR = 0;
  localparam int unsigned RAS_DEPTH_DEF   = 4;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_RET,
    SRC_CALL,
    SRC_JMP,
    SRC_BR,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty only flags underflow.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic [PTR_W:0]   o_cnt,
  output logic             o_ovf,
  output logic             o_unf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_top_idx;

  assign w_full    = (r_cnt == (PTR_W+1)'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop && !i_push && !w_empty;
  assign o_ovf     = i_push && w_full;
  assign o_unf     = i_pop && !i_push && w_empty;
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_cnt     = r_cnt;

  // r_ptr is the next free slot; when full it also indexes the oldest entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!w_full) r_cnt <= r_cnt + (PTR_W+1)'(1);
    end else if (w_do_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall, branch, jump and call/return via a RAS.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int unsigned      STEP         = PC_STEP,
  parameter int unsigned      RAS_DEPTH    = RAS_DEPTH_DEF,
  parameter int unsigned      PTR_W        = $clog2(RAS_DEPTH)
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             stall,
  input  logic             br_en,
  input  logic [WIDTH-1:0] br_off,
  input  logic             jmp_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] jmp_tgt,
  output logic [WIDTH-1:0] douta,
  output logic [WIDTH-1:0] pc_seq,
  output logic [PTR_W:0]   ras_cnt,
  output logic             ras_err
);

  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);

  logic [WIDTH-1:0] r_pc;
  logic             r_err;
  pc_src_e          w_src;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_top;
  logic             w_push;
  logic             w_pop;
  logic             w_misal;
  logic             w_ovf;
  logic             w_unf;

  assign pc_seq   = r_pc + WIDTH'(STEP);
  assign w_br_tgt = pc_seq + br_off;
  assign douta    = r_pc;
  assign ras_err  = r_err;

  always_comb begin
    w_src = SRC_SEQ;
    if (stall)        w_src = SRC_HOLD;
    else if (ret_en)  w_src = SRC_RET;
    else if (call_en) w_src = SRC_CALL;
    else if (jmp_en)  w_src = SRC_JMP;
    else if (br_en)   w_src = SRC_BR;
  end

  always_comb begin
    w_next  = pc_seq;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_misal = 1'b0;
    case (w_src)
      SRC_HOLD: w_next = r_pc;
      SRC_RET: begin
        w_pop = 1'b1;
        if (ras_cnt != '0) w_next = w_top;
      end
      SRC_CALL, SRC_JMP: begin
        w_push  = (w_src == SRC_CALL);
        w_next  = jmp_tgt & ~LOW_MASK;
        w_misal = (jmp_tgt & LOW_MASK) != '0;
      end
      SRC_BR: begin
        w_next  = w_br_tgt & ~LOW_MASK;
        w_misal = (w_br_tgt & LOW_MASK) != '0;
      end
      default: w_next = pc_seq;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_pc  <= RESET_VECTOR;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_next;
      if (w_misal || w_ovf || w_unf) r_err <= 1'b1;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH),
    .PTR_W (PTR_W)
  ) u_ras (
    .i_clk  (clka),
    .i_rst  (rsta),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (pc_seq),
    .o_top  (w_top),
    .o_cnt  (ras_cnt),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with WIDTH=32, STEP=4, RAS_DEPTH=4, RESET_VECTOR=0.
module tb_pc_unit;

  logic        clka = 1'b0;
  logic        rsta = 1'b0;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_off = '0;
  logic        jmp_en = 1'b0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic [31:0] jmp_tgt = '0;
  logic [31:0] douta;
  logic [31:0] pc_seq;
  logic [2:0]  ras_cnt;
  logic        ras_err;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0),
    .STEP         (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clka    (clka),
    .rsta    (rsta),
    .stall   (stall),
    .br_en   (br_en),
    .br_off  (br_off),
    .jmp_en  (jmp_en),
    .call_en (call_en),
    .ret_en  (ret_en),
    .jmp_tgt (jmp_tgt),
    .douta   (douta),
    .pc_seq  (pc_seq),
    .ras_cnt (ras_cnt),
    .ras_err (ras_err)
  );

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_en = 0; jmp_en = 0; call_en = 0; ret_en = 0; rsta = 0;
  endtask

  task automatic do_jmp(input logic [31:0] t);
    jmp_en = 1; jmp_tgt = t; tick(); idle();
  endtask

  task automatic do_call(input logic [31:0] t);
    call_en = 1; jmp_tgt = t; tick(); idle();
  endtask

  task automatic do_ret();
    ret_en = 1; tick(); idle();
  endtask

  task automatic do_reset();
    idle(); rsta = 1; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rsta = 1; tick(); tick(); idle();
    checks++; if (douta !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", douta, 32'h0); end
    checks++; if (ras_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", ras_cnt); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ras_err); end
  endtask

  task automatic test_seq_stall();
    logic [31:0] exp_seq [6];
    exp_seq[0] = 32'h4;  exp_seq[1] = 32'h8;  exp_seq[2] = 32'hC;
    exp_seq[3] = 32'hC;  exp_seq[4] = 32'hC;  exp_seq[5] = 32'h10;
    for (int i = 0; i < 6; i++) begin
      stall = (i == 3 || i == 4);
      tick();
      checks++; if (douta !== exp_seq[i]) begin errors++; $display("FAIL seq_stall[%0d]: got %h want %h", i, douta, exp_seq[i]); end
    end
    idle();
    checks++; if (pc_seq !== 32'h14) begin errors++; $display("FAIL pc_seq: got %h want %h", pc_seq, 32'h14); end
  endtask

  task automatic test_branch_jump();
    br_en = 1; br_off = 32'hFFFF_FFF8; tick(); idle();
    checks++; if (douta !== 32'h0C) begin errors++; $display("FAIL br_neg: got %h want %h", douta, 32'h0C); end
    do_jmp(32'h100);
    checks++; if (douta !== 32'h100) begin errors++; $display("FAIL jmp: got %h want %h", douta, 32'h100); end
    jmp_en = 1; br_en = 1; jmp_tgt = 32'h180; br_off = 32'h40; tick(); idle();
    checks++; if (douta !== 32'h180) begin errors++; $display("FAIL jmp_over_br: got %h want %h", douta, 32'h180); end
    br_en = 1; br_off = 32'h10; tick(); idle();
    checks++; if (douta !== 32'h194) begin errors++; $display("FAIL br_pos: got %h want %h", douta, 32'h194); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL br_err: got %b want 0", ras_err); end
  endtask

  task automatic test_call_ret();
    do_jmp(32'h20);
    call_en = 1; br_en = 1; br_off = 32'h40; jmp_tgt = 32'h200; tick(); idle();
    checks++; if (douta !== 32'h200 || ras_cnt !== 3'd1) begin errors++; $display("FAIL call1: got %h/%0d want 200/1", douta, ras_cnt); end
    tick();
    do_call(32'h300);
    checks++; if (douta !== 32'h300 || ras_cnt !== 3'd2) begin errors++; $display("FAIL call2: got %h/%0d want 300/2", douta, ras_cnt); end
    ret_en = 1; call_en = 1; jmp_tgt = 32'h700; tick(); idle();
    checks++; if (douta !== 32'h208 || ras_cnt !== 3'd1) begin errors++; $display("FAIL ret1: got %h/%0d want 208/1", douta, ras_cnt); end
    do_ret();
    checks++; if (douta !== 32'h24 || ras_cnt !== 3'd0) begin errors++; $display("FAIL ret2: got %h/%0d want 24/0", douta, ras_cnt); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL callret_err: got %b want 0", ras_err); end
  endtask

  task automatic test_overflow_underflow();
    logic [31:0] exp_pop [4];
    exp_pop[0] = 32'h5004; exp_pop[1] = 32'h4004; exp_pop[2] = 32'h3004; exp_pop[3] = 32'h2004;
    do_jmp(32'h1000);
    for (int unsigned i = 2; i <= 5; i++) do_call(32'(i) << 12);
    checks++; if (ras_cnt !== 3'd4 || ras_err !== 1'b0) begin errors++; $display("FAIL full: got %0d/%b want 4/0", ras_cnt, ras_err); end
    do_call(32'h6000);
    checks++; if (ras_cnt !== 3'd4 || ras_err !== 1'b1) begin errors++; $display("FAIL ovf: got %0d/%b want 4/1", ras_cnt, ras_err); end
    for (int i = 0; i < 4; i++) begin
      do_ret();
      checks++; if (douta !== exp_pop[i] || ras_cnt !== 3'(3 - i)) begin errors++; $display("FAIL pop[%0d]: got %h/%0d want %h/%0d", i, douta, ras_cnt, exp_pop[i], 3 - i); end
    end
    do_ret();
    checks++; if (douta !== 32'h2008 || ras_cnt !== 3'd0) begin errors++; $display("FAIL unf: got %h/%0d want 2008/0", douta, ras_cnt); end
  endtask

  task automatic test_wrap_align();
    do_reset();
    do_jmp(32'hFFFF_FFFC);
    checks++; if (pc_seq !== 32'h0) begin errors++; $display("FAIL wrap_seq: got %h want 0", pc_seq); end
    tick();
    checks++; if (douta !== 32'h0 || ras_err !== 1'b0) begin errors++; $display("FAIL wrap: got %h/%b want 0/0", douta, ras_err); end
    do_jmp(32'h103);
    checks++; if (douta !== 32'h100 || ras_err !== 1'b1) begin errors++; $display("FAIL align_jmp: got %h/%b want 100/1", douta, ras_err); end
    br_en = 1; br_off = 32'h2; tick(); idle();
    checks++; if (douta !== 32'h104) begin errors++; $display("FAIL align_br: got %h want 104", douta); end
    stall = 1; tick(); tick(); idle();
    checks++; if (douta !== 32'h104 || ras_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %h/%b want 104/1", douta, ras_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_ret();
    do_call(32'h400); do_call(32'h500); do_call(32'h600);
    checks++; if (ras_cnt !== 3'd3 || ras_err !== 1'b1) begin errors++; $display("FAIL pre_rst: got %0d/%b want 3/1", ras_cnt, ras_err); end
    rsta = 1; call_en = 1; stall = 1; jmp_tgt = 32'h800; tick(); idle();
    checks++; if (douta !== 32'h0 || ras_cnt !== 3'd0 || ras_err !== 1'b0) begin errors++; $display("FAIL rst_mid: got %h/%0d/%b want 0/0/0", douta, ras_cnt, ras_err); end
    tick();
    checks++; if (douta !== 32'h4) begin errors++; $display("FAIL post_rst: got %h want 4", douta); end
  endtask

  initial begin
    test_reset();
    test_seq_stall();
    test_branch_jump();
    test_call_ret();
    test_overflow_underflow();
    test_wrap_align();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
